// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI field widths and entry packing offsets
package axi_pkg;

    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 2;
    localparam int BURST_W = 2;
    localparam int LOCK_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;

    // Entry layout, LSB first: prot, cache, lock, burst, size, len, addr, id.
    localparam int PROT_LSB   = 0;
    localparam int CACHE_LSB  = PROT_LSB + PROT_W;
    localparam int LOCK_LSB   = CACHE_LSB + CACHE_W;
    localparam int BURST_LSB  = LOCK_LSB + LOCK_W;
    localparam int SIZE_LSB   = BURST_LSB + BURST_W;
    localparam int LEN_LSB    = SIZE_LSB + SIZE_W;
    localparam int ADDR_LSB   = LEN_LSB + LEN_W;
    localparam int ID_LSB     = ADDR_LSB + ADDR_W;
    localparam int REQ_BASE_W = ID_LSB;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/axi_req_fifo_ctrl.sv
// rtl/axi_req_fifo_ctrl.sv - pointers, occupancy count, status and sticky error flags
module axi_req_fifo_ctrl
    import axi_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_en,
    input  logic          read_en,
    input  logic          clr_err,
    output logic          wr_ok,
    output logic          rd_ok,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("axi_req_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_bad_level
        $error("axi_req_fifo: AF_LEVEL and AE_LEVEL must not exceed DEPTH");
    end

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A read on a full FIFO frees the slot the write lands in this same edge.
    assign rd_ok = read_en && !empty;
    assign wr_ok = write_en && (!full || read_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);

            if (wr_ok && !rd_ok)
                count <= count + CW'(1);
            else if (rd_ok && !wr_ok)
                count <= count - CW'(1);

            // A fresh error outranks a clear in the same cycle.
            if (write_en && !wr_ok)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;

            if (read_en && !rd_ok)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_req_fifo.sv
// rtl/axi_req_fifo.sv - AXI request FIFO top; AXI_REQ_FIFO_REG_OUT_EN selects a registered head output
module axi_req_fifo
    import axi_pkg::*;
#(
    parameter int TAG_BITS = 2,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int DW      = REQ_BASE_W + TAG_BITS,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_en,
    input  logic          read_en,
    input  logic [DW-1:0] entry_in,
    output logic [DW-1:0] entry_out,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    input  logic          clr_err,
    output logic          overflow,
    output logic          underflow
);

    logic          wr_ok;
    logic          rd_ok;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] mem [DEPTH];

    axi_req_fifo_ctrl #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .write_en     (write_en),
        .read_en      (read_en),
        .clr_err      (clr_err),
        .wr_ok        (wr_ok),
        .rd_ok        (rd_ok),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Storage is deliberately left unreset; count gates everything visible.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= entry_in;
    end

`ifdef AXI_REQ_FIFO_REG_OUT_EN
    logic [DW-1:0] head;
    logic [AW-1:0] rd_next;

    assign rd_next = rd_ptr + AW'(1);

    // Preload the entry that becomes the head after this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
        end else if (rd_ok) begin
            if (count > CW'(1))
                head <= mem[rd_next];
            else if (wr_ok)
                head <= entry_in;
        end else if (wr_ok && empty) begin
            head <= entry_in;
        end
    end

    assign entry_out = head;
`else
    assign entry_out = empty ? '0 : mem[rd_ptr];
`endif

endmodule

// File: tb/tb_axi_req_fifo.sv
// tb/tb_axi_req_fifo.sv - randomized and directed bench for axi_req_fifo against a queue model
module tb_axi_req_fifo;
    import axi_pkg::*;

    localparam int TAG_BITS = 2;
    localparam int DEPTH    = 4;
    localparam int DW       = REQ_BASE_W + TAG_BITS;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_en;
    logic          read_en;
    logic          clr_err;
    logic [DW-1:0] entry_in;
    logic [DW-1:0] entry_out;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] model_q [$];
    logic          m_ovf;
    logic          m_udf;

    axi_req_fifo #(
        .TAG_BITS (TAG_BITS),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_en     (write_en),
        .read_en      (read_en),
        .entry_in     (entry_in),
        .entry_out    (entry_out),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_entry(input int id, input logic [31:0] addr);
        logic [16:0] low;
        logic [TAG_BITS-1:0] tag;
        low = 17'($urandom);
        tag = TAG_BITS'(id);
        return {tag, addr, low};
    endfunction

    function automatic logic [31:0] addr_of(input logic [DW-1:0] e);
        return e[ADDR_LSB +: ADDR_W];
    endfunction

    task automatic check_all();
        int n;
        n = model_q.size();
        check("count", 64'(count), 64'(n));
        check("empty", 64'(empty), 64'(n == 0));
        check("full", 64'(full), 64'(n == DEPTH));
        check("almost_full", 64'(almost_full), 64'(n >= DEPTH - 1));
        check("almost_empty", 64'(almost_empty), 64'(n <= 1));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("underflow", 64'(underflow), 64'(m_udf));
        if (n != 0)
            check("entry_out", 64'(entry_out), 64'(model_q[0]));
`ifndef AXI_REQ_FIFO_REG_OUT_EN
        else
            check("entry_out_empty", 64'(entry_out), 64'(0));
`endif
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic step(input logic we, input logic re, input logic clr, input logic [DW-1:0] d);
        int  n;
        bit  wr;
        bit  rd;
        write_en = we;
        read_en  = re;
        clr_err  = clr;
        entry_in = d;
        @(posedge clk);
        n  = model_q.size();
        wr = we && (n < DEPTH || re);
        rd = re && (n > 0);
        if (we && !wr) m_ovf = 1'b1;
        else if (clr)  m_ovf = 1'b0;
        if (re && !rd) m_udf = 1'b1;
        else if (clr)  m_udf = 1'b0;
        if (rd) void'(model_q.pop_front());
        if (wr) model_q.push_back(d);
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
        clr_err  = 1'b0;
        check_all();
    endtask

    initial begin
        rst      = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        clr_err  = 1'b0;
        entry_in = '0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;

        // Fill to full, then drain in order.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, mk_entry(i, 32'h1000 + i));
            check("fill_count", 64'(count), 64'(i + 1));
        end
        check("full_at_4", 64'(full), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("pop_order", 64'(addr_of(entry_out)), 64'(32'h1000 + i));
            step(0, 1, 0, '0);
        end
        check("drained_empty", 64'(empty), 64'd1);

        // Full with simultaneous read and write.
        for (int i = 0; i < 4; i++) step(1, 0, 0, mk_entry(i, 32'h1000 + i));
        step(1, 1, 0, mk_entry(0, 32'h2000));
        check("pass_count", 64'(count), 64'd4);
        check("pass_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("pass_order", 64'(addr_of(entry_out)), (i == 3) ? 64'h2000 : 64'(32'h1001 + i));
            step(0, 1, 0, '0);
        end

        // Overflow is sticky until cleared.
        for (int i = 0; i < 4; i++) step(1, 0, 0, mk_entry(i, 32'h1100 + i));
        step(1, 0, 0, mk_entry(3, 32'hdead));
        check("ovf_set", 64'(overflow), 64'd1);
        step(0, 0, 0, '0);
        check("ovf_sticky", 64'(overflow), 64'd1);
        step(0, 0, 1, '0);
        check("ovf_clr", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, '0);

        // Empty with read and write together.
        step(1, 1, 0, mk_entry(1, 32'h3000));
        check("udf_set", 64'(underflow), 64'd1);
        check("udf_count", 64'(count), 64'd1);
        check("udf_head", 64'(addr_of(entry_out)), 64'h3000);
        step(0, 1, 1, '0);

        // Streaming through the wrap point.
        step(1, 0, 0, mk_entry(0, 32'h4000));
        for (int i = 1; i < 10; i++) begin
            step(1, 1, 0, mk_entry(i, 32'h4000 + i));
            check("wrap_head", 64'(addr_of(entry_out)), 64'(32'h4000 + i));
            check("wrap_bound", 64'(count <= CW'(DEPTH)), 64'd1);
        end
        step(0, 1, 0, '0);

        // Asynchronous reset mid-burst with an error flag raised.
        for (int i = 0; i < 4; i++) step(1, 0, 0, mk_entry(i, 32'h5000 + i));
        step(1, 0, 0, mk_entry(0, 32'hbad));
        step(0, 1, 0, '0);
        check("pre_rst_count", 64'(count), 64'd3);
        rst = 1'b0;
        #1;
        model_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_ovf", 64'(overflow), 64'd0);
        #2;
        rst = 1'b1;
        @(negedge clk);
        step(1, 0, 0, mk_entry(2, 32'h6000));
        check("post_rst_head", 64'(addr_of(entry_out)), 64'h6000);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 6, mk_entry($urandom, $urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_req_fifo.md
Name: axi_req_fifo

Overview:
- Parametrised synchronous FIFO for AXI address/request entries ({id, addr, len, size, burst, lock, cache, prot}).
- Successor to the fixed 2-deep request buffer: configurable depth and tag width, occupancy count, almost-full/almost-empty thresholds, full-with-read pass-through, and error flags.
- Sits between the master request arbiter and the slave address channel in the interconnect.

Parameters:
- TAG_BITS, 2: width of the ID field; entry width is 49+TAG_BITS.
- DEPTH, 4: number of entries; power of two, minimum 2.
- AF_LEVEL, DEPTH-1: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL.
- Derived local constants: DW = 49+TAG_BITS; AW = clog2(DEPTH); CW = AW+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- write_en  in  1  push request.
- read_en  in  1  pop request.
- entry_in  in  DW  entry to push; ID field in the MSBs, prot in the LSBs.
- entry_out  out  DW  head entry (first-word fall-through).
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  CW  current occupancy, 0..DEPTH.
- clr_err  in  1  synchronous clear of the error flags.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers and count go to 0; overflow/underflow go to 0.
  - Outputs: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), count=0, entry_out=0.
  - Storage array is not reset.
- Pointers:
  - Read and write pointers are AW bits and wrap from DEPTH-1 to 0.
  - Count is a registered CW-bit counter. No pointer-comparison full/empty.
- Read acceptance: rd_ok = read_en && !empty.
- Write acceptance: wr_ok = write_en && (!full || read_en).
  - When full, a simultaneous read frees the slot, so the write is accepted in the same cycle.
- Count update:
  - wr_ok only: count +1.
  - rd_ok only: count -1.
  - Both: count unchanged, both pointers advance.
- Empty with read_en and write_en together: the read is rejected and underflow is set; the write is accepted (count 0→1). No same-cycle bypass to entry_out.
- Write data is captured into mem[wr_ptr] at the clock edge when wr_ok.
- entry_out:
  - Combinational mem[rd_ptr] when !empty; forced to all zeros when empty.
  - Zero-latency head visibility: a pushed entry appears on entry_out the cycle after the push edge.
- Status flags: all combinational from the registered count, so they update in the cycle after the causing edge.
- Error flags:
  - overflow is set when write_en && !wr_ok; underflow is set when read_en && !rd_ok.
  - Both are cleared by clr_err. If clr_err and a new error occur in the same cycle, set wins.
- Reset mid-operation: all state is abandoned immediately; no partial write completes.
- Parameter checks: elaboration error if DEPTH is not a power of two, or if AF_LEVEL > DEPTH or AE_LEVEL > DEPTH.

Optional Feature:
- Macro: AXI_REQ_FIFO_REG_OUT_EN.
- Defined:
  - entry_out is driven from a flop loaded with the next head on every pop or first fill.
  - A pushed entry still appears one cycle after the push edge.
  - Removes the read-mux path from timing.
  - The flop resets to 0 and holds its last value when empty instead of forcing zeros.
- Undefined: combinational output as described under Behaviour.
- Count, flags and handshake timing are identical in both builds.

Decomposition:
- Shared package axi_pkg holds the common AXI constants and field widths:
  - ADDR_W=32, LEN_W=4, SIZE_W=2, BURST_W=2, LOCK_W=2, CACHE_W=4, PROT_W=3.
  - Field offset constants for packing entries.
- This package keeps entry packing consistent with the arbiter and decoder.
- One natural sub-module: axi_req_fifo_ctrl, holding the pointers, count, flags and error logic. The storage array and output mux stay in the top.

Test Plan:
- Reset, then push 4 entries (IDs 0..3, addr 0x1000+i) with DEPTH=4 → count steps 1,2,3,4; almost_full at 3; full at 4; pops return entries in order 0x1000..0x1003; empty=1 at end.
- Full, then write_en and read_en together with entry addr 0x2000 → both accepted; count stays 4; overflow=0; 0x2000 is popped 4th.
- Full, then write_en alone → write dropped; overflow=1 and sticky; clr_err pulse → overflow=0.
- Empty, then read_en and write_en together (addr 0x3000) → underflow=1; count=1; next cycle entry_out=0x3000.
- Push and pop 10 entries → pointer wrap exercised; data order preserved; count never exceeds 4.
- Assert rst low mid-burst with count=3 → count=0, empty=1, flags=0 asynchronously; the first push after release appears at the head.
